// File: rtl/comm_seq_pkg.sv
// Shared types for the command sequencer: FSM states, the positive-ack
// code and the layout of one queued command.
package comm_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT_SNT,
        S_WAIT_RESP,
        S_CHECK,
        S_CLR,
        S_ABORT
    } state_t;

    localparam logic [7:0] POS_ACK = 8'hA5;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [15:0] data;
    } entry_t;

endpackage

// File: rtl/cmd_fifo.sv
// Command queue: DEPTH x 24-bit FIFO with flush. Writes while full are
// dropped; a write and a pop in the same cycle both take effect.
module cmd_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr,
    input  logic [23:0] i_din,
    input  logic        i_rd,
    input  logic        i_flush,
    output logic [23:0] o_dout,
    output logic        o_full,
    output logic        o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [23:0]  r_mem [DEPTH];
    logic         w_do_wr;
    logic         w_do_rd;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

    assign w_do_wr = i_wr && !o_full && !i_flush;
    assign w_do_rd = i_rd && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/comm_sequencer.sv
// Drains a queue of commands to a CommMaster, one at a time, checking each
// response for a positive ack and retrying on timeout or negative ack.
module comm_sequencer
    import comm_seq_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TIMEOUT_CYC = 1250000,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_cmd,
    input  logic [15:0] wr_data,
    output logic        full,
    input  logic        go,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        send_cmd,
    input  logic        frm_snt,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic        clr_resp_rdy,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  err_cmd,
    output logic [7:0]  ack_cnt
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t        r_state;
    state_t        w_next;
    logic          w_pop;
    logic          w_flush;
    logic          w_retry;
    logic          w_empty;
    logic          w_timeout;
    logic          w_can_retry;
    logic [23:0]   w_fifo_dout;
    entry_t        w_head;
    entry_t        w_wr_entry;

    logic [TW-1:0] r_tmo;
    logic [RW-1:0] r_retry;
    logic          r_nak;
    logic [7:0]    r_cmd;
    logic [15:0]   r_data;
    logic          r_done;
    logic          r_err;
    logic [7:0]    r_err_cmd;
    logic [7:0]    r_ack_cnt;

    assign w_wr_entry = '{cmd: wr_cmd, data: wr_data};
    assign w_head     = entry_t'(w_fifo_dout);

    cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (wr_en),
        .i_din   (w_wr_entry),
        .i_rd    (w_pop),
        .i_flush (w_flush),
        .o_dout  (w_fifo_dout),
        .o_full  (full),
        .o_empty (w_empty)
    );

    assign w_timeout   = (r_tmo == TW'(TIMEOUT_CYC - 1));
    assign w_can_retry = (r_retry < RW'(MAX_RETRY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_pop   = 1'b0;
        w_flush = 1'b0;
        w_retry = 1'b0;
        unique case (r_state)
            S_IDLE:      if (go && !w_empty) w_next = S_LOAD;
            S_LOAD: begin
                w_pop  = 1'b1;
                w_next = S_SEND;
            end
            S_SEND:      w_next = S_WAIT_SNT;
            S_WAIT_SNT: begin
                // A response seen before the frame-sent pulse is still accepted.
                if (resp_rdy)       w_next = S_CHECK;
                else if (frm_snt)   w_next = S_WAIT_RESP;
                else if (w_timeout) w_retry = 1'b1;
            end
            S_WAIT_RESP: begin
                if (resp_rdy)       w_next = S_CHECK;
                else if (w_timeout) w_retry = 1'b1;
            end
            S_CHECK:     w_next = S_CLR;
            S_CLR: begin
                if (r_nak)          w_retry = 1'b1;
                else if (!w_empty)  w_next = S_LOAD;
                else                w_next = S_IDLE;
            end
            S_ABORT: begin
                w_flush = 1'b1;
                w_next  = S_IDLE;
            end
            default:     w_next = S_IDLE;
        endcase
        if (w_retry) w_next = w_can_retry ? S_SEND : S_ABORT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo     <= '0;
            r_retry   <= '0;
            r_nak     <= 1'b0;
            r_cmd     <= '0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cmd <= '0;
            r_ack_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: if (go) begin
                    r_err     <= 1'b0;
                    r_ack_cnt <= '0;
                    if (w_empty) r_done <= 1'b1;
                end
                S_LOAD: begin
                    r_cmd   <= w_head.cmd;
                    r_data  <= w_head.data;
                    r_retry <= '0;
                end
                S_SEND:                  r_tmo <= '0;
                S_WAIT_SNT, S_WAIT_RESP: r_tmo <= r_tmo + TW'(1);
                S_CHECK: begin
                    r_nak <= (resp != POS_ACK);
                    if (resp == POS_ACK && r_ack_cnt != 8'hFF)
                        r_ack_cnt <= r_ack_cnt + 8'd1;
                end
                S_CLR:   if (w_next == S_IDLE) r_done <= 1'b1;
                S_ABORT: begin
                    r_err     <= 1'b1;
                    r_err_cmd <= r_cmd;
                end
                default: ;
            endcase
            if (w_retry && w_can_retry) r_retry <= r_retry + RW'(1);
        end
    end

    assign cmd          = r_cmd;
    assign data         = r_data;
    assign send_cmd     = (r_state == S_SEND);
    assign clr_resp_rdy = (r_state == S_CLR);
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign err          = r_err;
    assign err_cmd      = r_err_cmd;
    assign ack_cnt      = r_ack_cnt;

endmodule

// File: tb/tb_comm_sequencer.sv
// Self-checking bench for comm_sequencer: a scripted CommMaster responder,
// table vectors, hand-written corner sequences and a randomized model run.
module tb_comm_sequencer;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TC    = 100;
    localparam int unsigned MR    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_cmd;
    logic [15:0] wr_data;
    logic        full;
    logic        go;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        send_cmd;
    logic        frm_snt;
    logic        resp_rdy;
    logic [7:0]  resp;
    logic        clr_resp_rdy;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  err_cmd;
    logic [7:0]  ack_cnt;

    always #5 clk = ~clk;

    comm_sequencer #(
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (TC),
        .MAX_RETRY   (MR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_cmd       (wr_cmd),
        .wr_data      (wr_data),
        .full         (full),
        .go           (go),
        .cmd          (cmd),
        .data         (data),
        .send_cmd     (send_cmd),
        .frm_snt      (frm_snt),
        .resp_rdy     (resp_rdy),
        .resp         (resp),
        .clr_resp_rdy (clr_resp_rdy),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_cmd      (err_cmd),
        .ack_cnt      (ack_cnt)
    );

    typedef struct {
        bit          respond;
        logic [7:0]  rbyte;
        bit          early;
        int unsigned d1;
        int unsigned d2;
    } act_t;

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] data;
        logic [7:0]  r0, r1, r2;
        bit          early;
        int unsigned exp_sends;
        int unsigned exp_ack;
        bit          exp_err;
    } vec_t;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    act_t        script[$];
    logic [23:0] entries[$];
    logic [23:0] exp_sends[$];
    logic [23:0] sends[$];
    int          send_cyc[$];
    int          done_cnt;
    int          clr_cnt;
    int unsigned exp_ack, exp_clr, exp_done;
    bit          exp_err;
    logic [7:0]  exp_errcmd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (send_cmd) begin
            sends.push_back({cmd, data});
            send_cyc.push_back(cyc);
        end
        if (done) done_cnt++;
        if (clr_resp_rdy) clr_cnt++;
    end

    // Scripted CommMaster: each send_cmd consumes one action from the script.
    initial begin
        act_t a;
        bit   got;
        frm_snt  = 1'b0;
        resp_rdy = 1'b0;
        resp     = 8'h00;
        forever begin
            @(negedge clk);
            if (send_cmd) begin
                if (script.size() > 0) a = script.pop_front();
                else a = '{1'b0, 8'h00, 1'b0, 1, 1};
                repeat (a.d1) @(negedge clk);
                if (!(a.respond && a.early)) begin
                    frm_snt = 1'b1;
                    @(negedge clk);
                    frm_snt = 1'b0;
                    if (a.respond) repeat (a.d2) @(negedge clk);
                end
                if (a.respond) begin
                    resp     = a.rbyte;
                    resp_rdy = 1'b1;
                    got      = 1'b0;
                    for (int k = 0; k < 2 * TC; k++) begin
                        @(negedge clk);
                        if (clr_resp_rdy) begin
                            got = 1'b1;
                            break;
                        end
                    end
                    resp_rdy = 1'b0;
                    chk("clr_resp_rdy_arrives", 32'(got), 32'd1);
                end
            end
        end
    end

    task automatic push(input logic [23:0] e);
        @(negedge clk);
        wr_en = 1'b1;
        {wr_cmd, wr_data} = e;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_go();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic run_check(input string tag, input bit do_push, input bit extra_go);
        sends.delete();
        send_cyc.delete();
        done_cnt = 0;
        clr_cnt  = 0;
        if (do_push) foreach (entries[i]) push(entries[i]);
        pulse_go();
        if (extra_go) begin
            repeat (3) @(negedge clk);
            pulse_go();
        end
        for (int k = 0; k < 20000 && busy; k++) @(negedge clk);
        if (busy) chk({tag, ".idle_timeout"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk({tag, ".n_sends"}, 32'(sends.size()), 32'(exp_sends.size()));
        foreach (exp_sends[i])
            if (i < sends.size()) chk($sformatf("%s.send%0d", tag, i), 32'(sends[i]), 32'(exp_sends[i]));
        chk({tag, ".ack_cnt"}, 32'(ack_cnt), 32'(exp_ack));
        chk({tag, ".err"}, 32'(err), 32'(exp_err));
        if (exp_err) chk({tag, ".err_cmd"}, 32'(err_cmd), 32'(exp_errcmd));
        chk({tag, ".done_cnt"}, 32'(done_cnt), 32'(exp_done));
        chk({tag, ".clr_cnt"}, 32'(clr_cnt), 32'(exp_clr));
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        script.delete();
    endtask

    function automatic act_t rand_act();
        act_t        a;
        int unsigned r;
        r       = $urandom_range(0, 99);
        a.early = ($urandom_range(0, 3) == 0);
        a.d1    = $urandom_range(1, 3);
        a.d2    = $urandom_range(0, 3);
        if (r < 60) begin
            a.respond = 1'b1;
            a.rbyte   = 8'hA5;
        end else if (r < 88) begin
            a.respond = 1'b1;
            a.rbyte   = 8'($urandom);
            if (a.rbyte == 8'hA5) a.rbyte = 8'hA4;
        end else begin
            a.respond = 1'b0;
            a.rbyte   = 8'h00;
        end
        return a;
    endfunction

    // Reference: walk the command list, consuming one random outcome per send.
    task automatic gen_random();
        int unsigned n, tries;
        act_t        a;
        entries.delete();
        exp_sends.delete();
        script.delete();
        exp_ack = 0;
        exp_clr = 0;
        exp_err = 1'b0;
        n = $urandom_range(1, DEPTH);
        for (int i = 0; i < int'(n); i++) entries.push_back({8'($urandom), 16'($urandom)});
        foreach (entries[i]) begin
            if (exp_err) break;
            tries = 0;
            forever begin
                exp_sends.push_back(entries[i]);
                a = rand_act();
                script.push_back(a);
                if (a.respond) exp_clr++;
                if (a.respond && a.rbyte == 8'hA5) begin
                    exp_ack = (exp_ack < 255) ? exp_ack + 1 : 255;
                    break;
                end
                tries++;
                if (tries > MR) begin
                    exp_err    = 1'b1;
                    exp_errcmd = entries[i][23:16];
                    break;
                end
            end
        end
        exp_done = exp_err ? 0 : 1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt[5];
        vt[0] = '{8'h02, 16'h0EAD, 8'hA5, 8'h00, 8'h00, 1'b0, 1, 1, 1'b0};
        vt[1] = '{8'h10, 16'h1234, 8'h00, 8'hA5, 8'h00, 1'b0, 2, 1, 1'b0};
        vt[2] = '{8'h33, 16'hBEEF, 8'h5A, 8'hA4, 8'hA5, 1'b1, 3, 1, 1'b0};
        vt[3] = '{8'h44, 16'h0001, 8'h00, 8'hFF, 8'h00, 1'b0, 3, 0, 1'b1};
        vt[4] = '{8'hFF, 16'hFFFF, 8'hA5, 8'h00, 8'h00, 1'b1, 1, 1, 1'b0};

        rst = 1'b1; wr_en = 1'b0; wr_cmd = '0; wr_data = '0; go = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.cmd", 32'(cmd), 0);
        chk("rst.data", 32'(data), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.send_clr_done", 32'({send_cmd, clr_resp_rdy, done}), 0);
        chk("rst.err", 32'({err, err_cmd}), 0);
        chk("rst.ack_cnt", 32'(ack_cnt), 0);
        chk("rst.full", 32'(full), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vt[v]) begin
            entries.delete();
            exp_sends.delete();
            entries.push_back({vt[v].cmd, vt[v].data});
            for (int i = 0; i < int'(vt[v].exp_sends); i++) exp_sends.push_back({vt[v].cmd, vt[v].data});
            script.push_back('{1'b1, vt[v].r0, vt[v].early, 2, 1});
            script.push_back('{1'b1, vt[v].r1, vt[v].early, 2, 1});
            script.push_back('{1'b1, vt[v].r2, vt[v].early, 2, 1});
            exp_ack    = vt[v].exp_ack;
            exp_err    = vt[v].exp_err;
            exp_errcmd = vt[v].cmd;
            exp_done   = vt[v].exp_err ? 0 : 1;
            exp_clr    = vt[v].exp_sends;
            run_check($sformatf("vec%0d", v), 1'b1, 1'b0);
        end

        // Three commands in order, with a go pulse while busy that must be ignored.
        entries = '{24'h01_1111, 24'h02_2222, 24'h03_3333};
        exp_sends = entries;
        script.delete();
        for (int i = 0; i < 3; i++) script.push_back('{1'b1, 8'hA5, 1'b0, 1, 2});
        exp_ack = 3; exp_err = 1'b0; exp_done = 1; exp_clr = 3;
        run_check("three_cmds", 1'b1, 1'b1);

        // No response: three sends a timeout apart, abort, rest of queue flushed.
        entries = '{24'h7C_1111, 24'h7D_2222, 24'h7E_3333};
        exp_sends = '{24'h7C_1111, 24'h7C_1111, 24'h7C_1111};
        script.delete();
        for (int i = 0; i < 3; i++) script.push_back('{1'b0, 8'h00, 1'b0, 2, 0});
        exp_ack = 0; exp_err = 1'b1; exp_errcmd = 8'h7C; exp_done = 0; exp_clr = 0;
        run_check("timeout", 1'b1, 1'b0);
        for (int i = 1; i < send_cyc.size(); i++)
            chk($sformatf("timeout.spacing%0d", i),
                32'((send_cyc[i] - send_cyc[i-1] >= int'(TC) - 1) && (send_cyc[i] - send_cyc[i-1] <= int'(TC) + 3)), 1);
        entries.delete(); exp_sends.delete();
        exp_err = 1'b0; exp_done = 1;
        run_check("after_abort_empty", 1'b1, 1'b0);

        // Reset while waiting for a response.
        push(24'h5C_C0DE);
        script.push_back('{1'b0, 8'h00, 1'b0, 2, 0});
        pulse_go();
        repeat (12) @(negedge clk);
        chk("midrst.busy_before", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("midrst.cmd_data", 32'({cmd, data}), 0);
        chk("midrst.busy", 32'(busy), 0);
        chk("midrst.pulses", 32'({send_cmd, clr_resp_rdy, done}), 0);
        chk("midrst.err", 32'({err, err_cmd}), 0);
        chk("midrst.ack_cnt", 32'(ack_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        script.delete();
        sends.delete(); done_cnt = 0; clr_cnt = 0;
        repeat (250) @(negedge clk);
        chk("midrst.no_sends", 32'(sends.size()), 0);
        chk("midrst.no_clr", 32'(clr_cnt), 0);
        chk("midrst.no_done", 32'(done_cnt), 0);
        entries.delete(); exp_sends.delete();
        exp_ack = 0; exp_err = 1'b0; exp_done = 1; exp_clr = 0;
        run_check("midrst.go_empty", 1'b1, 1'b0);

        // Overfill: DEPTH+1 writes, last one dropped.
        entries.delete(); exp_sends.delete(); script.delete();
        for (int i = 0; i <= int'(DEPTH); i++) entries.push_back({8'(8'h40 + i), 16'(16'h0101 * i)});
        for (int i = 0; i <= int'(DEPTH); i++) begin
            push(entries[i]);
            if (i == int'(DEPTH) - 2) chk("fill.not_full", 32'(full), 0);
            if (i >= int'(DEPTH) - 1) chk($sformatf("fill.full%0d", i), 32'(full), 1);
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            exp_sends.push_back(entries[i]);
            script.push_back('{1'b1, 8'hA5, 1'b0, 1, 1});
        end
        exp_ack = DEPTH; exp_err = 1'b0; exp_done = 1; exp_clr = DEPTH;
        run_check("fill", 1'b0, 1'b0);

        for (int r = 0; r < 16; r++) begin
            gen_random();
            run_check($sformatf("rand%0d", r), 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
